// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard unit: forwarding codes,
// divide-timer state encoding, stage-control bundle and register-match helper.
package mips_pkg;

  localparam int DIV_CYCLES_DEFAULT = 32;
  localparam int DIV_CNT_W          = 6;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic clear_d;
    logic clear_e;
    logic clear_m;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // $0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] write_reg,
                                     input logic       reg_write,
                                     input logic [4:0] src_reg);
    return reg_write && (write_reg != 5'd0) && (write_reg == src_reg);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_div_timer.sv
// Multi-cycle divide stall timer: freezes the pipeline for exactly DIV_CYCLES
// EX cycles, then flags the release cycle with div_done.
module hazard_div_timer
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_start_i,
  input  logic exc_m_i,
  output logic div_stall_o,
  output logic div_busy_o,
  output logic div_done_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_stall_o = 1'b0;
    div_busy_o  = 1'b0;
    div_done_o  = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        // The launch cycle already freezes EX, so it counts as one of DIV_CYCLES.
        if (div_start_i) begin
          div_stall_o = 1'b1;
          div_busy_o  = 1'b1;
          state_d     = DIV_BUSY;
          cnt_d       = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        div_busy_o = 1'b1;
        if (cnt_q == '0) begin
          // Release cycle: return to IDLE even if div_start_i is still high.
          div_done_o = 1'b1;
          state_d    = DIV_IDLE;
        end else begin
          div_stall_o = 1'b1;
          cnt_d       = cnt_q - DIV_CNT_W'(1);
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (exc_m_i) begin
      state_d    = DIV_IDLE;
      cnt_d      = '0;
      div_done_o = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch stalls, operand forwarding,
// divide freeze and exception flush. Define HAZARD_FWD_EN to enable forwarding.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic       reg_write_e,
  input  logic       mem_to_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_m,
  input  logic       mem_to_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_w,
  input  logic       div_start_e,
  input  logic       exc_m,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       clear_d,
  output logic       clear_e,
  output logic       clear_m,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       div_busy,
  output logic       div_done
);

  logic match_e_rs, match_e_rt;
  logic match_m_rs, match_m_rt;
  logic match_w_rs, match_w_rt;
  logic load_use, branch_hz, raw_stall, hz_stall;
  logic div_stall, div_busy_raw, div_done_raw;
  logic [1:0] fwd_a_e_raw, fwd_b_e_raw;
  logic fwd_a_d_raw, fwd_b_d_raw;
  stage_ctrl_t ctrl;

  hazard_div_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_start_i (div_start_e),
    .exc_m_i     (exc_m),
    .div_stall_o (div_stall),
    .div_busy_o  (div_busy_raw),
    .div_done_o  (div_done_raw)
  );

  assign match_e_rs = reg_match(write_reg_e, reg_write_e, rs_d);
  assign match_e_rt = reg_match(write_reg_e, reg_write_e, rt_d);
  assign match_m_rs = reg_match(write_reg_m, reg_write_m, rs_d);
  assign match_m_rt = reg_match(write_reg_m, reg_write_m, rt_d);
  assign match_w_rs = reg_match(write_reg_w, reg_write_w, rs_d);
  assign match_w_rt = reg_match(write_reg_w, reg_write_w, rt_d);

  assign load_use  = mem_to_reg_e && (match_e_rs || match_e_rt);
  // Branches resolve in ID, so an EX result or a pending MEM load is too late.
  assign branch_hz = branch_d && (match_e_rs || match_e_rt ||
                                  (mem_to_reg_m && (match_m_rs || match_m_rt)));

`ifdef HAZARD_FWD_EN
  assign raw_stall   = 1'b0;
  assign fwd_a_e_raw = fwd_sel(reg_match(write_reg_m, reg_write_m, rs_e),
                               reg_match(write_reg_w, reg_write_w, rs_e));
  assign fwd_b_e_raw = fwd_sel(reg_match(write_reg_m, reg_write_m, rt_e),
                               reg_match(write_reg_w, reg_write_w, rt_e));
  assign fwd_a_d_raw = match_m_rs;
  assign fwd_b_d_raw = match_m_rt;
`else
  // With no bypass network, every in-flight producer must drain first.
  assign raw_stall   = match_e_rs || match_e_rt || match_m_rs || match_m_rt ||
                       match_w_rs || match_w_rt;
  assign fwd_a_e_raw = FWD_REG;
  assign fwd_b_e_raw = FWD_REG;
  assign fwd_a_d_raw = 1'b0;
  assign fwd_b_d_raw = 1'b0;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs_e, rt_e};
`endif

  assign hz_stall = load_use || branch_hz || raw_stall;

  // Priority: exception flush > divide freeze > data-hazard stall.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst_n) begin
      if (exc_m) begin
        ctrl.clear_d = 1'b1;
        ctrl.clear_e = 1'b1;
        ctrl.clear_m = 1'b1;
      end else if (div_stall) begin
        ctrl.en_f    = 1'b0;
        ctrl.en_d    = 1'b0;
        ctrl.en_e    = 1'b0;
        ctrl.clear_m = 1'b1;
      end else if (hz_stall) begin
        ctrl.en_f    = 1'b0;
        ctrl.en_d    = 1'b0;
        ctrl.clear_e = 1'b1;
      end
    end
  end

  assign en_f    = ctrl.en_f;
  assign en_d    = ctrl.en_d;
  assign en_e    = ctrl.en_e;
  assign clear_d = ctrl.clear_d;
  assign clear_e = ctrl.clear_e;
  assign clear_m = ctrl.clear_m;

  // Outputs are held at their idle values for the whole reset, not just after it.
  assign fwd_a_e  = rst_n ? fwd_a_e_raw : FWD_REG;
  assign fwd_b_e  = rst_n ? fwd_b_e_raw : FWD_REG;
  assign fwd_a_d  = rst_n && fwd_a_d_raw;
  assign fwd_b_d  = rst_n && fwd_b_d_raw;
  assign div_busy = rst_n && div_busy_raw;
  assign div_done = rst_n && div_done_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes reference-model
// expectations per cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int DIV_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       branch_d, reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m;
  logic       reg_write_w, div_start_e, exc_m;
  logic       en_f, en_d, en_e, clear_d, clear_e, clear_m;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, div_busy, div_done;

  hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .div_start_e(div_start_e), .exc_m(exc_m),
    .en_f(en_f), .en_d(en_d), .en_e(en_e),
    .clear_d(clear_d), .clear_e(clear_e), .clear_m(clear_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Field order: en_f en_d en_e clr_d clr_e clr_m fwd_a_e fwd_b_e fwd_a_d fwd_b_d busy done
  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          div_left = 0;  // BUSY cycles still to come in the current divide
  logic [13:0] got_v;

  assign got_v = {en_f, en_d, en_e, clear_d, clear_e, clear_m,
                  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, div_busy, div_done};

  function automatic bit hit(input logic [4:0] wr, input logic we, input logic [4:0] r);
    return we && (wr != 0) && (wr == r);
  endfunction

  function automatic logic [13:0] model_out();
    bit ef, ed, ee, cd, ce, cm, fad, fbd, busy, done, freeze, stall;
    bit ex_hit, mem_hit, wb_hit;
    logic [1:0] fa, fb;
    ef = 1; ed = 1; ee = 1; cd = 0; ce = 0; cm = 0;
    fa = 0; fb = 0; fad = 0; fbd = 0; busy = 0; done = 0;
    if (rst_n) begin
      ex_hit  = hit(write_reg_e, reg_write_e, rs_d) || hit(write_reg_e, reg_write_e, rt_d);
      mem_hit = hit(write_reg_m, reg_write_m, rs_d) || hit(write_reg_m, reg_write_m, rt_d);
      wb_hit  = hit(write_reg_w, reg_write_w, rs_d) || hit(write_reg_w, reg_write_w, rt_d);
      stall   = (mem_to_reg_e && ex_hit) ||
                (branch_d && (ex_hit || (mem_to_reg_m && mem_hit)));
`ifdef HAZARD_FWD_EN
      fa  = hit(write_reg_m, reg_write_m, rs_e) ? 2'b10 :
            hit(write_reg_w, reg_write_w, rs_e) ? 2'b01 : 2'b00;
      fb  = hit(write_reg_m, reg_write_m, rt_e) ? 2'b10 :
            hit(write_reg_w, reg_write_w, rt_e) ? 2'b01 : 2'b00;
      fad = hit(write_reg_m, reg_write_m, rs_d);
      fbd = hit(write_reg_m, reg_write_m, rt_d);
`else
      stall = stall || ex_hit || mem_hit || wb_hit;
`endif
      freeze = (div_left == 0 && div_start_e) || div_left > 1;
      busy   = div_left > 0 || div_start_e;
      done   = div_left == 1 && !exc_m;
      if (exc_m) begin
        cd = 1; ce = 1; cm = 1;
      end else if (freeze) begin
        ef = 0; ed = 0; ee = 0; cm = 1;
      end else if (stall) begin
        ef = 0; ed = 0; ce = 1;
      end
    end
    return {ef, ed, ee, cd, ce, cm, fa, fb, fad, fbd, busy, done};
  endfunction

  // Called at each rising edge with the inputs that were present at that edge.
  task automatic advance_model();
    if (!rst_n || exc_m)   div_left = 0;
    else if (div_left > 0) div_left = div_left - 1;
    else if (div_start_e)  div_left = DIV_CYCLES;
  endtask

  task automatic tick();
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = model_out();
    exp_q.push_back(e);
  endtask

  task automatic quiet();
    rst_n = 1; rs_d = 0; rt_d = 0; branch_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
    write_reg_m = 0; reg_write_m = 0; mem_to_reg_m = 0;
    write_reg_w = 0; reg_write_w = 0; div_start_e = 0; exc_m = 0;
  endtask

  task automatic rand_inputs();
    rs_d = 5'($urandom_range(0, 7));  rt_d = 5'($urandom_range(0, 7));
    rs_e = 5'($urandom_range(0, 7));  rt_e = 5'($urandom_range(0, 7));
    write_reg_e = 5'($urandom_range(0, 7));
    write_reg_m = 5'($urandom_range(0, 7));
    write_reg_w = 5'($urandom_range(0, 7));
    reg_write_e  = $urandom_range(0, 3) != 0;
    reg_write_m  = $urandom_range(0, 3) != 0;
    reg_write_w  = $urandom_range(0, 3) != 0;
    mem_to_reg_e = $urandom_range(0, 2) == 0;
    mem_to_reg_m = $urandom_range(0, 2) == 0;
    branch_d     = $urandom_range(0, 3) == 0;
    div_start_e  = $urandom_range(0, 15) == 0;
    exc_m        = $urandom_range(0, 31) == 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (got_v !== mon_e.v) begin
          n_errors++;
          $display("FAIL %s: got=%b expected=%b (en_f en_d en_e clr_d clr_e clr_m fa fb fad fbd busy done)",
                   mon_e.tag, got_v, mon_e.v);
        end
      end
    end
  end

  initial begin
    quiet();
    rst_n = 0;

    // Reset with hazards and a divide request on the inputs: outputs stay idle.
    for (int i = 0; i < 4; i++) begin
      tick(); rand_inputs(); rst_n = 0; div_start_e = 1; exc_m = 0;
      push($sformatf("reset%0d", i));
    end

    // Load-use on rs_d, then the $0 and write-disable boundaries.
    tick(); quiet(); write_reg_e = 2; reg_write_e = 1; mem_to_reg_e = 1; rs_d = 2;
    push("lw_use");
    tick(); quiet(); push("lw_after");
    tick(); quiet(); write_reg_e = 0; reg_write_e = 1; mem_to_reg_e = 1; rs_d = 0;
    push("lw_r0");
    tick(); quiet(); write_reg_e = 4; reg_write_e = 0; mem_to_reg_e = 1; rt_d = 4;
    push("lw_nowrite");
    tick(); quiet(); branch_d = 1; write_reg_m = 6; reg_write_m = 1; mem_to_reg_m = 1; rt_d = 6;
    push("branch_mem_load");

`ifdef HAZARD_FWD_EN
    tick(); quiet(); rs_e = 5; write_reg_m = 5; write_reg_w = 5; reg_write_m = 1; reg_write_w = 1;
    push("fwd_mem_prio");
    tick(); quiet(); rs_e = 5; write_reg_m = 0; write_reg_w = 5; reg_write_m = 1; reg_write_w = 1;
    push("fwd_wb");
`else
    tick(); quiet(); write_reg_w = 7; reg_write_w = 1; rt_d = 7;
    push("nofwd_wb_stall");
    tick(); quiet(); rt_e = 3; write_reg_m = 3; reg_write_m = 1;
    push("nofwd_tied0");
`endif

    // Full divide: DIV_CYCLES frozen cycles, done only in the last BUSY cycle.
    tick(); quiet(); div_start_e = 1; push("div_launch");
    for (int i = 1; i <= DIV_CYCLES; i++) begin
      tick(); quiet(); div_start_e = 1; push($sformatf("div_busy%0d", i));
    end
    tick(); quiet(); push("div_after");
    tick(); quiet(); push("div_idle");

    // Exception in the 10th BUSY cycle aborts the divide.
    tick(); quiet(); div_start_e = 1; push("exc_launch");
    for (int i = 1; i <= 10; i++) begin
      tick(); quiet(); div_start_e = 1; exc_m = (i == 10);
      push($sformatf("exc_busy%0d", i));
    end
    tick(); quiet(); push("exc_next");

    // Exception in the launch cycle keeps the timer idle.
    tick(); quiet(); div_start_e = 1; exc_m = 1; push("exc_launch_same");
    tick(); quiet(); push("exc_launch_next");

    // Reset mid-cycle while BUSY, released before the next edge.
    tick(); quiet(); div_start_e = 1; push("rst_div_launch");
    for (int i = 1; i <= 5; i++) begin
      tick(); quiet(); div_start_e = 1; push($sformatf("rst_div_busy%0d", i));
    end
    tick(); quiet(); div_start_e = 1; rst_n = 0; div_left = 0; push("rst_mid_cycle");
    #6; rst_n = 1; div_start_e = 0;
    tick(); quiet(); push("rst_release_idle");
    tick(); quiet(); push("rst_release_idle2");

    for (int i = 0; i < 3000; i++) begin
      tick(); rand_inputs(); push("random");
    end

    tick(); quiet(); push("final");
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got=%0d pending expectations required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
